cypher_detector_stream: RTL

- Parametrised successor of the fixed 4x4-bit cypher detector.
- Watches a stream of SYM_W-bit symbols for a programmable CYPHER_LEN-symbol cypher and counts detections in a saturating sum.
- Adds a valid qualifier, overlapping and non-overlapping match modes, and a latched cypher with an explicit load.
- Adds a synchronous clear and a sticky saturation flag.
- Sits between the keypad/symbol source and the display/score logic.

---
 rtl/cypher_pkg.sv | 38 +++
 rtl/cypher_window.sv | 101 ++++++++++
 rtl/cypher_detector_stream.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cypher_pkg.sv
// ---------------------------------------------------------------------------
// cypher_pkg
// Shared definitions for the streaming cypher detector:
//   - state_t           : detector FSM encoding (IDLE / ARMED)
//   - DEF_*             : default symbol width, cypher length and counter width
//   - MAX_*             : upper bounds for the generic symbol-extract helper
//   - cypher_sym()      : returns symbol k of a packed cypher (symbol 0 in the
//                         least significant SYM_W bits)
// ---------------------------------------------------------------------------
package cypher_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam int DEF_SYM_W      = 4;
    localparam int DEF_CYPHER_LEN = 4;
    localparam int DEF_SUM_W      = 10;

    // Bounds for the helper below; callers zero-extend their cypher to
    // MAX_CYPHER_BITS and truncate the result back to their own SYM_W.
    localparam int MAX_SYM_W       = 32;
    localparam int MAX_CYPHER_BITS = 1024;

    function automatic logic [MAX_SYM_W-1:0] cypher_sym(
        input logic [MAX_CYPHER_BITS-1:0] cy,
        input int                         k,
        input int                         sym_w
    );
        logic [MAX_CYPHER_BITS-1:0] shifted;
        logic [MAX_SYM_W-1:0]       mask;
        shifted = cy >> (k * sym_w);
        mask    = (MAX_SYM_W'(1) << sym_w) - MAX_SYM_W'(1);
        return shifted[MAX_SYM_W-1:0] & mask;
    endfunction

endpackage : cypher_pkg

// File: rtl/cypher_window.sv
// ---------------------------------------------------------------------------
// cypher_window
// Sliding window of the last CYPHER_LEN-1 accepted symbols, a saturating fill
// counter and the comparator that decides whether the symbol being accepted
// this cycle completes the cypher.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   accept      in   a symbol is accepted on this edge
//   flush       in   empty the window (fill=0) on this edge
//   overlap     in   1: keep sliding after a match, 0: restart after a match
//   sym_in      in   symbol being presented
//   cypher      in   latched cypher, symbol 0 in the low bits
//   match_next  out  combinational: this accepting edge completes the cypher
// ---------------------------------------------------------------------------
module cypher_window
    import cypher_pkg::*;
#(
    parameter int SYM_W      = DEF_SYM_W,
    parameter int CYPHER_LEN = DEF_CYPHER_LEN
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         accept,
    input  logic                         flush,
    input  logic                         overlap,
    input  logic [SYM_W-1:0]             sym_in,
    input  logic [SYM_W*CYPHER_LEN-1:0]  cypher,
    output logic                         match_next
);

    localparam int WIN_LEN = CYPHER_LEN - 1;
    localparam int FILL_W  = $clog2(CYPHER_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN_LEN);

    // Index 0 is the oldest symbol, index WIN_LEN-1 the newest.
    logic [SYM_W-1:0]      win_reg  [WIN_LEN];
    logic [SYM_W-1:0]      win_next [WIN_LEN];
    logic [FILL_W-1:0]     fill_reg;
    logic [FILL_W-1:0]     fill_next;
    logic [SYM_W-1:0]      cyp_sym  [CYPHER_LEN];
    logic [CYPHER_LEN-1:0] sym_eq;

    genvar gi;

    generate
        for (gi = 0; gi < CYPHER_LEN; gi++) begin : g_cyp_sym
            assign cyp_sym[gi] = SYM_W'(cypher_sym(MAX_CYPHER_BITS'(cypher), gi, SYM_W));
        end

        // Stored symbols line up with cypher symbols 0..CYPHER_LEN-2; the
        // incoming symbol is compared against the last cypher symbol.
        for (gi = 0; gi < WIN_LEN; gi++) begin : g_cmp
            assign sym_eq[gi] = (win_reg[gi] == cyp_sym[gi]);
        end
        assign sym_eq[CYPHER_LEN-1] = (sym_in == cyp_sym[CYPHER_LEN-1]);

        for (gi = 0; gi < WIN_LEN; gi++) begin : g_shift
            if (gi == WIN_LEN - 1) begin : g_tail
                assign win_next[gi] = sym_in;
            end else begin : g_body
                assign win_next[gi] = win_reg[gi+1];
            end
        end
    endgenerate

    // Symbols left over from before a flush are never compared because the
    // fill counter gates the match, so the shift register itself is not wiped.
    assign match_next = accept && (fill_reg == FILL_FULL) && (&sym_eq);

    always_comb begin
        fill_next = fill_reg;
        if (flush) begin
            fill_next = '0;
        end else if (accept) begin
            if (match_next && !overlap) begin
                fill_next = '0;
            end else if (fill_reg != FILL_FULL) begin
                fill_next = fill_reg + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill_reg <= '0;
            for (int i = 0; i < WIN_LEN; i++) begin
                win_reg[i] <= '0;
            end
        end else begin
            fill_reg <= fill_next;
            if (accept) begin
                for (int i = 0; i < WIN_LEN; i++) begin
                    win_reg[i] <= win_next[i];
                end
            end
        end
    end

endmodule : cypher_window

// File: rtl/cypher_detector_stream.sv
// ---------------------------------------------------------------------------
// cypher_detector_stream
// Watches a stream of SYM_W-bit symbols for a latched CYPHER_LEN-symbol
// cypher and counts detections in a saturating counter with a sticky
// saturation flag.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   fullcypher   in   cypher to latch; symbol k at [k*SYM_W +: SYM_W]
//   cypher_load  in   latch fullcypher, arm detector, empty window
//   seq_input    in   incoming symbol
//   seq_valid    in   seq_input is valid this cycle
//   overlap      in   1: overlapping matches, 0: non-overlapping
//   clear        in   synchronous clear of sum, sat, window and hit
//   armed        out  cypher latched, symbols accepted
//   hit          out  one-cycle pulse per detection
//   sum          out  saturating detection count
//   sat          out  sticky: a detection arrived while sum was at max
// ---------------------------------------------------------------------------
module cypher_detector_stream
    import cypher_pkg::*;
#(
    parameter int SYM_W      = DEF_SYM_W,
    parameter int CYPHER_LEN = DEF_CYPHER_LEN,
    parameter int SUM_W      = DEF_SUM_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SYM_W*CYPHER_LEN-1:0]  fullcypher,
    input  logic                         cypher_load,
    input  logic [SYM_W-1:0]             seq_input,
    input  logic                         seq_valid,
    input  logic                         overlap,
    input  logic                         clear,
    output logic                         armed,
    output logic                         hit,
    output logic [SUM_W-1:0]             sum,
    output logic                         sat
);

    localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

    state_t                        state_reg;
    state_t                        state_next;
    logic [SYM_W*CYPHER_LEN-1:0]   cypher_reg;
    logic                          hit_reg;
    logic [SUM_W-1:0]              sum_reg;
    logic                          sat_reg;
    logic                          accept;
    logic                          flush;
    logic                          match_next;

    // Load and clear both take priority over an incoming symbol.
    assign accept = (state_reg == ST_ARMED) && seq_valid && !cypher_load && !clear;
    assign flush  = cypher_load || clear;

    cypher_window #(
        .SYM_W      (SYM_W),
        .CYPHER_LEN (CYPHER_LEN)
    ) u_window (
        .clock      (clock),
        .reset      (reset),
        .accept     (accept),
        .flush      (flush),
        .overlap    (overlap),
        .sym_in     (seq_input),
        .cypher     (cypher_reg),
        .match_next (match_next)
    );

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state. ARMED is only left through reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (cypher_load) state_next = ST_ARMED;
            ST_ARMED: state_next = ST_ARMED;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        armed = (state_reg == ST_ARMED);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cypher_reg <= '0;
        end else if (cypher_load) begin
            cypher_reg <= fullcypher;
        end
    end

    // match_next is already suppressed by clear, so hit drops on clear too.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_reg <= 1'b0;
        end else begin
            hit_reg <= match_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_reg <= '0;
            sat_reg <= 1'b0;
        end else if (clear) begin
            sum_reg <= '0;
            sat_reg <= 1'b0;
        end else if (match_next) begin
            if (sum_reg == SUM_MAX) begin
                sat_reg <= 1'b1;
            end else begin
                sum_reg <= sum_reg + SUM_W'(1);
            end
        end
    end

    assign hit = hit_reg;
    assign sum = sum_reg;
    assign sat = sat_reg;

endmodule : cypher_detector_stream
